// File: rtl/pattern_sequencer_if.sv
// Bus interface for pattern_sequencer: edge-table programming, run control and status.
//   master : drives cfg_we/cfg_addr/cfg_time/cfg_level, len/period/repeat_en, start/stop;
//            observes busy, pattern_out, period_done, err
//   slave  : the sequencer side of the same signals
interface pattern_sequencer_if #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned TW    = 16
);
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [TW-1:0]    cfg_time;
  logic             cfg_level;
  logic [IDX_W:0]   len;
  logic [TW-1:0]    period;
  logic             repeat_en;
  logic             start;
  logic             stop;
  logic             busy;
  logic             pattern_out;
  logic             period_done;
  logic             err;

  modport master (
    output cfg_we, cfg_addr, cfg_time, cfg_level, len, period, repeat_en, start, stop,
    input  busy, pattern_out, period_done, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_time, cfg_level, len, period, repeat_en, start, stop,
    output busy, pattern_out, period_done, err
  );
endinterface

// File: rtl/pattern_sequencer.sv
// Programmable waveform sequencer: replays a table of timed level changes on
// pattern_out, once or repeating every `period` ticks.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - pattern_sequencer_if.slave: table writes (cfg_*), run setup
//          (len, period, repeat_en), start/stop, and registered status
//          outputs busy, pattern_out, period_done, err
// Optional feature macro: PATSEQ_PRESCALE_EN adds parameter PRESCALE and makes
// one tick last PRESCALE clocks; undefined means one tick per clock.
// IDX_W and TW must match the parameters of the connected interface.
module pattern_sequencer #(
  parameter int unsigned EDGES      = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned TW         = 16,
  parameter logic        INIT_LEVEL = 1'b0
`ifdef PATSEQ_PRESCALE_EN
  , parameter int unsigned PRESCALE = 10
`endif
) (
  input logic                clk,
  input logic                rst,
  pattern_sequencer_if.slave bus
);

  localparam int unsigned CW = IDX_W + 1;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              pat_q, pat_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     len_q, len_d;
  logic [TW-1:0]     period_q, period_d;
  logic              rep_q, rep_d;

  logic [TW-1:0]     tab_time_q [EDGES];
  logic [EDGES-1:0]  tab_level_q;

  logic              tab_we_c;
  logic              cfg_ok_c;
  logic              tick_c;
  logic [IDX_W-1:0]  ent_idx_c;
  logic [TW-1:0]     ent_time_c;
  logic              ent_level_c;

  // Edge table: writable only while not running; not reset by design
  assign tab_we_c = bus.cfg_we && !busy_q && ({1'b0, bus.cfg_addr} < CW'(EDGES));

  always_ff @(posedge clk) begin
    if (tab_we_c) begin
      tab_time_q[bus.cfg_addr]  <= bus.cfg_time;
      tab_level_q[bus.cfg_addr] <= bus.cfg_level;
    end
  end

  // Run setup legality check, applied when start is seen in IDLE
  assign cfg_ok_c = (bus.len != '0) && (bus.len <= CW'(EDGES)) && (bus.period != '0);

  // Entry currently under examination (only meaningful while idx_q < len_q)
  assign ent_idx_c   = idx_q[IDX_W-1:0];
  assign ent_time_c  = tab_time_q[ent_idx_c];
  assign ent_level_c = tab_level_q[ent_idx_c];

`ifdef PATSEQ_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;

  // Tick fires on the first clock of each PRESCALE-clock window
  assign tick_c = (pre_q == '0);

  always_comb begin
    pre_d = '0;
    if (state_q == S_RUN && !bus.stop) begin
      pre_d = (pre_q == PW'(PRESCALE - 1)) ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end
`else
  assign tick_c = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      pat_q    <= INIT_LEVEL;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      period_q <= '0;
      rep_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      pat_q    <= pat_d;
      done_q   <= done_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      period_q <= period_d;
      rep_q    <= rep_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    pat_d    = pat_q;
    done_d   = 1'b0;
    err_d    = err_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    len_d    = len_q;
    period_d = period_q;
    rep_d    = rep_q;

    case (state_q)
      S_IDLE: begin
        pat_d = INIT_LEVEL;
        if (bus.start && !bus.stop) begin
          if (cfg_ok_c) begin
            state_d  = S_RUN;
            busy_d   = 1'b1;
            err_d    = 1'b0;
            timer_d  = '0;
            idx_d    = '0;
            len_d    = bus.len;
            period_d = bus.period;
            rep_d    = bus.repeat_en;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pat_d   = INIT_LEVEL;
          timer_d = '0;
          idx_d   = '0;
        end else if (tick_c) begin
          // First tick of a period restores the idle level; a time-0 entry overrides it
          if (timer_q == '0) pat_d = INIT_LEVEL;

          if (idx_q < len_q) begin
            if (ent_time_c == timer_q) begin
              pat_d = ent_level_c;
              idx_d = idx_q + CW'(1);
            end else if (ent_time_c < timer_q) begin
              // Out-of-order or duplicate time: skip the entry and flag it
              err_d = 1'b1;
              idx_d = idx_q + CW'(1);
            end
          end

          if (timer_q == period_q - TW'(1)) begin
            done_d  = 1'b1;
            timer_d = '0;
            idx_d   = '0;
            if (!rep_q) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.pattern_out = pat_q;
  assign bus.period_done = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: directed scenarios with literal
// expectations plus randomized runs compared every cycle against an
// event-list model of the waveform.
module tb_pattern_sequencer;
  localparam int unsigned EDGES = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned TW    = 16;
  localparam int unsigned LW    = IDX_W + 1;
  localparam logic        INIT  = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pattern_sequencer_if #(.IDX_W(IDX_W), .TW(TW)) bus ();

  pattern_sequencer #(
    .EDGES(EDGES), .IDX_W(IDX_W), .TW(TW), .INIT_LEVEL(INIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_tab_t [EDGES];
  bit  m_tab_l [EDGES];
  bit  m_run, m_busy, m_pat, m_done, m_err;
  int  m_len, m_period, c0, cyc;
  bit  m_rep;
  int  fire_t[$];
  bit  fire_l[$];
  int  err_t[$];

  // Walk the table once: each entry is examined on the tick after the previous one resolved.
  function automatic void build_events();
    int e;
    fire_t.delete(); fire_l.delete(); err_t.delete();
    e = 0;
    for (int i = 0; i < m_len; i++) begin
      if (e >= m_period) break;
      if (m_tab_t[i] >= e) begin
        if (m_tab_t[i] >= m_period) break;
        fire_t.push_back(m_tab_t[i]);
        fire_l.push_back(m_tab_l[i]);
        e = m_tab_t[i] + 1;
      end else begin
        err_t.push_back(e);
        e = e + 1;
      end
    end
  endfunction

  // Level after the j-th edge of a period (j = 1..period)
  function automatic bit level_at(input int j);
    bit l;
    l = INIT;
    foreach (fire_t[i]) if (fire_t[i] < j) l = fire_l[i];
    return l;
  endfunction

  always @(posedge clk or posedge rst) begin
    int k, j;
    if (rst) begin
      m_run = 0; m_busy = 0; m_pat = INIT; m_done = 0; m_err = 0;
    end else begin
      cyc++;
      if (m_run) begin
        k = cyc - c0;
        if (bus.stop) begin
          m_run = 0; m_busy = 0; m_pat = INIT; m_done = 0;
        end else begin
          j = (k - 1) % m_period + 1;
          m_pat  = level_at(j);
          foreach (err_t[i]) if (err_t[i] + 1 == j) m_err = 1;
          m_done = (j == m_period);
          if (m_done && !m_rep) begin m_run = 0; m_busy = 0; end
        end
      end else begin
        m_pat = INIT; m_done = 0;
        if (bus.cfg_we && int'(bus.cfg_addr) < EDGES) begin
          m_tab_t[bus.cfg_addr] = int'(bus.cfg_time);
          m_tab_l[bus.cfg_addr] = bus.cfg_level;
        end
        if (bus.start && !bus.stop) begin
          if (bus.len >= 1 && bus.len <= EDGES && bus.period >= 1) begin
            m_run = 1; m_busy = 1; m_err = 0; c0 = cyc;
            m_len = int'(bus.len); m_period = int'(bus.period); m_rep = bus.repeat_en;
            build_events();
          end else begin
            m_err = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", bus.busy, m_busy);
      chk("pattern_out", bus.pattern_out, m_pat);
      chk("period_done", bus.period_done, m_done);
      chk("err", bus.err, m_err);
    end
  end

  // ---------------- stimulus ----------------
  int kk;

  task automatic wr(input int a, input int t, input bit l);
    bus.cfg_we = 1'b1; bus.cfg_addr = IDX_W'(a); bus.cfg_time = TW'(t); bus.cfg_level = l;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_start(input int l, input int p, input bit r);
    bus.len = LW'(l); bus.period = TW'(p); bus.repeat_en = r; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    kk = 0;
  endtask

  task automatic adv_to(input int target);
    repeat (target - kk) @(negedge clk);
    kk = target;
  endtask

  task automatic stop_pulse();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic load_base();
    wr(0, 0, 1); wr(1, 20, 0); wr(2, 50, 1); wr(3, 90, 0);
    wr(4, 140, 1); wr(5, 200, 0); wr(6, 250, 1); wr(7, 260, 0);
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_time = '0; bus.cfg_level = 0;
    bus.len = '0; bus.period = '0; bus.repeat_en = 0; bus.start = 0; bus.stop = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_pat", bus.pattern_out, 1'b0);
    chk("reset_done", bus.period_done, 1'b0);
    chk("reset_err", bus.err, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    load_base();

    // Repeating run, three periods
    do_start(6, 300, 1);
    chk("t1_k0_busy", bus.busy, 1'b1);
    adv_to(1);   chk("t1_k1_rise", bus.pattern_out, 1'b1);
    adv_to(20);  chk("t1_k20", bus.pattern_out, 1'b1);
    adv_to(21);  chk("t1_k21_fall", bus.pattern_out, 1'b0);
    adv_to(51);  chk("t1_k51_rise", bus.pattern_out, 1'b1);
    adv_to(299); chk("t1_k299_done", bus.period_done, 1'b0);
    adv_to(300); chk("t1_k300_done", bus.period_done, 1'b1);
    adv_to(301); chk("t1_k301_pat", bus.pattern_out, 1'b1);
                 chk("t1_k301_done", bus.period_done, 1'b0);
    adv_to(621); chk("t1_k621_fall", bus.pattern_out, 1'b0);
    adv_to(905); chk("t1_err", bus.err, 1'b0);
    stop_pulse();
    chk("t1_stop_busy", bus.busy, 1'b0);

    // Single period, then replay
    do_start(6, 300, 0);
    adv_to(141); chk("t2_k141", bus.pattern_out, 1'b1);
    adv_to(300); chk("t2_k300_done", bus.period_done, 1'b1);
                 chk("t2_k300_busy", bus.busy, 1'b0);
    adv_to(301); chk("t2_k301_pat", bus.pattern_out, 1'b0);
    do_start(6, 300, 0);
    adv_to(305);

    // Stop mid-run; start together with stop is refused
    do_start(6, 300, 1);
    adv_to(69);  chk("t3_k69", bus.pattern_out, 1'b1);
    bus.stop = 1'b1; adv_to(70); bus.stop = 1'b0;
    chk("t3_stop_pat", bus.pattern_out, 1'b0);
    chk("t3_stop_busy", bus.busy, 1'b0);
    chk("t3_stop_done", bus.period_done, 1'b0);
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("t3_startstop", bus.busy, 1'b0);
    repeat (3) @(negedge clk);

    // Out-of-order table
    wr(0, 30, 1); wr(1, 10, 0);
    do_start(2, 50, 0);
    adv_to(30); chk("t4_k30", bus.pattern_out, 1'b0);
    adv_to(31); chk("t4_k31_rise", bus.pattern_out, 1'b1);
                chk("t4_k31_err", bus.err, 1'b0);
    adv_to(32); chk("t4_k32_err", bus.err, 1'b1);
    adv_to(50); chk("t4_k50_pat", bus.pattern_out, 1'b1);
                chk("t4_k50_done", bus.period_done, 1'b1);
    adv_to(51); chk("t4_k51_pat", bus.pattern_out, 1'b0);
                chk("t4_err_sticky", bus.err, 1'b1);
    wr(0, 0, 1); wr(1, 20, 0);
    do_start(6, 300, 1);
    chk("t4_err_clear", bus.err, 1'b0);

    // Table write while busy is ignored
    adv_to(5);
    wr(1, 25, 1);
    stop_pulse();
    do_start(6, 300, 0);
    adv_to(21); chk("t5_k21", bus.pattern_out, 1'b0);
    adv_to(26); chk("t5_k26", bus.pattern_out, 1'b0);
    adv_to(302);

    // Illegal setups
    do_start(0, 10, 0);
    chk("t6_len0_err", bus.err, 1'b1);
    chk("t6_len0_busy", bus.busy, 1'b0);
    do_start(1, 5, 0);
    chk("t6_legal_err", bus.err, 1'b0);
    adv_to(7);
    do_start(3, 0, 0);
    chk("t6_per0_err", bus.err, 1'b1);
    do_start(1, 5, 0);
    adv_to(7);
    do_start(9, 20, 0);
    chk("t6_len9_err", bus.err, 1'b1);
    chk("t6_len9_busy", bus.busy, 1'b0);

    // Asynchronous reset mid-run; table survives
    do_start(6, 300, 1);
    adv_to(60); chk("t7_k60", bus.pattern_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_busy", bus.busy, 1'b0);
    chk("t7_rst_pat", bus.pattern_out, 1'b0);
    chk("t7_rst_done", bus.period_done, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    do_start(6, 300, 0);
    adv_to(21); chk("t7_k21", bus.pattern_out, 1'b0);
    adv_to(51); chk("t7_k51", bus.pattern_out, 1'b1);
    adv_to(302);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      int t;
      t = 0;
      for (int a = 0; a < EDGES; a++) begin
        if ($urandom_range(0, 5) == 0) t = $urandom_range(0, 70);
        else t = t + $urandom_range(0, 12);
        wr(a, t, 1'($urandom_range(0, 1)));
      end
      do_start($urandom_range(1, EDGES), $urandom_range(1, 60), 1'($urandom_range(0, 1)));
      for (int c = 0; c < int'($urandom_range(1, 150)); c++) begin
        bus.stop      = ($urandom_range(0, 39) == 0);
        bus.start     = ($urandom_range(0, 19) == 0);
        bus.len       = LW'($urandom_range(0, EDGES));
        bus.period    = TW'($urandom_range(0, 50));
        bus.repeat_en = 1'($urandom_range(0, 1));
        bus.cfg_we    = ($urandom_range(0, 9) == 0);
        bus.cfg_addr  = IDX_W'($urandom_range(0, EDGES - 1));
        bus.cfg_time  = TW'($urandom_range(0, 70));
        bus.cfg_level = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.start = 1'b0; bus.cfg_we = 1'b0; bus.stop = 1'b0;
      stop_pulse();
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Synthesizable programmable waveform sequencer. It replays a table of timed level changes on a single output, once or repeating at a fixed period. Test-pattern stimulus leaves hand-written delay statements and becomes a register-programmed block that can sit in front of any single-bit datapath input. Software/bench loads the edge table, then issues start/stop.

Parameters:
EDGES, 8, number of edge-table entries
IDX_W, 3, index width (clog2(EDGES))
TW, 16, timer / edge-time / period width in clock ticks
INIT_LEVEL, 0, level driven on pattern_out in IDLE and at the start of each period

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cfg_we  input  1  edge-table write strobe, ignored while busy=1
cfg_addr  input  IDX_W  table entry index
cfg_time  input  TW  tick at which the entry fires
cfg_level  input  1  level applied when the entry fires
len  input  IDX_W+1  active entry count (1..EDGES), sampled on start
period  input  TW  period length in ticks (>=1), sampled on start
repeat_en  input  1  1 = loop forever, 0 = one period; sampled on start
start  input  1  start request, level-sampled in IDLE
stop  input  1  synchronous abort
busy  output  1  high in RUN
pattern_out  output  1  generated waveform (registered)
period_done  output  1  one-cycle pulse at each period end
err  output  1  sticky: out-of-order edge or bad config; cleared on accepted start

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, pattern_out=INIT_LEVEL, period_done=0, err=0, timer=0, idx=0. Edge-table contents are not reset; they are undefined until written.
- Table write: on a clk edge with cfg_we=1 and busy=0, entry[cfg_addr] <= {cfg_time, cfg_level}. Addresses >= EDGES are ignored.
- IDLE -> RUN: requires start=1, stop=0, 1<=len<=EDGES and period>=1. On acceptance, latch len/period/repeat_en, set timer=0, idx=0, busy=1, err=0, pattern_out=INIT_LEVEL.
- start with an illegal len/period: stay in IDLE and set err=1.
- RUN, every cycle, evaluated in this order:
  - stop=1 -> next edge IDLE, busy=0, pattern_out=INIT_LEVEL. No period_done pulse. stop beats every other event.
  - idx<len and entry[idx].time==timer -> pattern_out <= entry[idx].level; idx++. At most one entry fires per cycle.
  - idx<len and entry[idx].time<timer (non-monotonic table or duplicate time) -> err=1; idx++; the entry is not applied.
  - timer==period_l-1 -> period_done=1 for one cycle; timer=0; idx=0; pattern_out=INIT_LEVEL on the next edge.
    - repeat_en_l=1: stay in RUN.
    - repeat_en_l=0: go to IDLE, busy=0.
    - An edge matching the final tick is applied on that same edge; the INIT_LEVEL restore takes effect on the following edge.
  - Otherwise: timer++.
- Timing: the start-accept edge is E0. An entry with time t changes pattern_out at edge E0+t+1. period_done goes high for the cycle after edge E0+period.
- Entries with time >= period never fire and set no error.
- Duplicate times: the first entry fires; the second flags err at the next tick.
- The timer never wraps past period_l-1. TW-bit arithmetic is unsigned.
- start while busy is ignored.

Optional Feature:
PATSEQ_PRESCALE_EN
- Defined: adds parameter PRESCALE (default 10) and an internal prescale counter. timer, edge matching and the period end advance only on every PRESCALE-th clk in RUN. All tick values above are then in units of PRESCALE clocks. The prescale counter clears on start, stop and rst.
- Undefined: one tick per clk. There is no PRESCALE parameter or counter.

Test Plan:
- Load (0,1),(20,0),(50,1),(90,0),(140,1),(200,0); len=6, period=300, repeat_en=1, start -> pattern_out edges at E0+1/21/51/91/141/201. period_done pulses every 300 cycles. Identical waveform on 3 consecutive periods. err=0.
- Same table, repeat_en=0 -> one period, then busy=0 and pattern_out=0 from the cycle after period_done. A new start replays it.
- Assert stop at E0+100 -> pattern_out=0 and busy=0 at the next edge; no period_done. start and stop asserted together in IDLE -> no start.
- Entries (30,1),(10,0), len=2, period=50 -> rises at E0+31, err=1 at E0+32, pattern_out never returns to 0 until the period end. Next accepted start clears err.
- len=0 or period=0 with start -> stays IDLE, err=1. cfg_we while busy -> table unchanged (verified by the next run's waveform).
- Assert rst at E0+60 (async, mid-clock) -> busy=0, pattern_out=0, period_done=0 immediately, without waiting for clk. Table retained. With PATSEQ_PRESCALE_EN and PRESCALE=10, the first table gives its first fall at E0+201.
